// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32 subset datapath: sequences fetch, decode, execute,
// memory and writeback, and traps on illegal encodings or memory handshake timeouts.
module multicycle_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 3,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic                     instr_valid_i,
    input  logic                     mem_ready_i,
    input  logic                     zero_i,
    output logic                     fetch_req_o,
    output logic                     mem_req_o,
    output logic                     IRWrite_o,
    output logic                     PCWrite_o,
    output logic                     PCSrc_o,
    output logic                     ALUsrc_o,
    output logic                     RegWrite_o,
    output logic                     MemWrite_o,
    output logic [CONTROL_WIDTH-1:0] ALUctrl_o,
    output logic [1:0]               ResultSrc_o,
    output logic [3:0]               state_o,
    output logic                     illegal_o,
    output logic [31:0]              instret_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd15
    } state_t;

    localparam logic [CONTROL_WIDTH-1:0] ALU_ADD = CONTROL_WIDTH'(0);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SUB = CONTROL_WIDTH'(1);
    localparam logic [CONTROL_WIDTH-1:0] ALU_AND = CONTROL_WIDTH'(2);
    localparam logic [CONTROL_WIDTH-1:0] ALU_OR  = CONTROL_WIDTH'(3);
    localparam logic [CONTROL_WIDTH-1:0] ALU_XOR = CONTROL_WIDTH'(4);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLT = CONTROL_WIDTH'(5);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLL = CONTROL_WIDTH'(6);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SRL = CONTROL_WIDTH'(7);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           instret_q, instret_d;

    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic [CONTROL_WIDTH-1:0] aluMap;
    logic                     mapOk;
    logic                     timeout;
    logic                     unused_instr;

    assign opcode       = instr_q[6:0];
    assign funct3       = instr_q[14:12];
    assign funct7b5     = instr_q[30];
    assign unused_instr = ^{instr_q[DATA_WIDTH-1:31], instr_q[29:15], instr_q[11:7]};
    assign timeout      = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // funct7[5] selects SUB only for register ops; it is illegal on shift-right in both forms
    always_comb begin
        aluMap = ALU_ADD;
        mapOk  = 1'b1;
        case (funct3)
            3'b000:  aluMap = (state_q == EXEC_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  aluMap = ALU_AND;
            3'b110:  aluMap = ALU_OR;
            3'b100:  aluMap = ALU_XOR;
            3'b010:  aluMap = ALU_SLT;
            3'b001:  aluMap = ALU_SLL;
            3'b101: begin
                aluMap = ALU_SRL;
                mapOk  = ~funct7b5;
            end
            default: mapOk = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        fetch_req_o = 1'b0;
        mem_req_o   = 1'b0;
        IRWrite_o   = 1'b0;
        PCWrite_o   = 1'b0;
        PCSrc_o     = 1'b0;
        ALUsrc_o    = 1'b0;
        RegWrite_o  = 1'b0;
        MemWrite_o  = 1'b0;
        ALUctrl_o   = ALU_ADD;
        ResultSrc_o = 2'b00;
        case (state_q)
            FETCH: begin
                fetch_req_o = rst_n;
                if (instr_valid_i) begin
                    IRWrite_o = rst_n;
                    instr_d   = instr_i;
                    state_d   = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = TRAP;
                endcase
            end
            EXEC_R, EXEC_I: begin
                ALUsrc_o  = (state_q == EXEC_I);
                ALUctrl_o = aluMap;
                state_d   = mapOk ? WB_ALU : TRAP;
            end
            MEM_ADDR: begin
                ALUsrc_o = 1'b1;
                if (funct3 != 3'b010) state_d = TRAP;
                else                  state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD, MEM_WR: begin
                mem_req_o  = 1'b1;
                MemWrite_o = (state_q == MEM_WR);
                if (mem_ready_i) begin
                    PCWrite_o = (state_q == MEM_WR);
                    state_d   = (state_q == MEM_WR) ? FETCH : WB_MEM;
                end else if (timeout) begin
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB_ALU, WB_MEM: begin
                RegWrite_o  = 1'b1;
                ResultSrc_o = (state_q == WB_MEM) ? 2'b01 : 2'b00;
                PCWrite_o   = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                ALUctrl_o = ALU_SUB;
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    PCWrite_o = 1'b1;
                    PCSrc_o   = funct3[0] ? ~zero_i : zero_i;
                    state_d   = FETCH;
                end else begin
                    state_d = TRAP;
                end
            end
            JAL: begin
                RegWrite_o  = 1'b1;
                ResultSrc_o = 2'b10;
                PCWrite_o   = 1'b1;
                PCSrc_o     = 1'b1;
                state_d     = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
        // every wait state starts counting from zero when it is entered
        if (state_d != state_q) cnt_d = '0;
    end

    assign instret_d = instret_q + 32'(PCWrite_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    assign state_o   = state_q;
    assign illegal_o = (state_q == TRAP);
    assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class through its
// state sequence and checks enables, wait/timeout behaviour, traps and reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        instr_valid_i, mem_ready_i, zero_i;
    logic        fetch_req_o, mem_req_o, IRWrite_o, PCWrite_o, PCSrc_o;
    logic        ALUsrc_o, RegWrite_o, MemWrite_o;
    logic [2:0]  ALUctrl_o;
    logic [1:0]  ResultSrc_o;
    logic [3:0]  state_o;
    logic        illegal_o;
    logic [31:0] instret_o;

    int          nVec = 0;
    int          nErr = 0;
    logic [31:0] expInstret;

    multicycle_ctrl #(.DATA_WIDTH(32), .CONTROL_WIDTH(3), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .mem_ready_i(mem_ready_i), .zero_i(zero_i), .fetch_req_o(fetch_req_o),
        .mem_req_o(mem_req_o), .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o),
        .PCSrc_o(PCSrc_o), .ALUsrc_o(ALUsrc_o), .RegWrite_o(RegWrite_o),
        .MemWrite_o(MemWrite_o), .ALUctrl_o(ALUctrl_o), .ResultSrc_o(ResultSrc_o),
        .state_o(state_o), .illegal_o(illegal_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset;
        rst_n = 1'b0;
        instr_i = '0; instr_valid_i = 1'b0; mem_ready_i = 1'b0; zero_i = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        expInstret = '0;
    endtask

    // Present one instruction word in FETCH and step through DECODE (drive only).
    task automatic fetchDecode(input logic [31:0] ins);
        instr_i = ins; instr_valid_i = 1'b1;
        nextCycle();
        instr_i = '0; instr_valid_i = 1'b0;
        nextCycle();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        instr_i = '0; instr_valid_i = 1'b0; mem_ready_i = 1'b0; zero_i = 1'b0;
        expInstret = '0;
        #2;
        nVec++; if (state_o !== 4'd0) begin nErr++; $display("FAIL reset_state got %0d want 0", state_o); end
        nVec++; if ({fetch_req_o, mem_req_o, IRWrite_o, PCWrite_o, RegWrite_o, MemWrite_o, illegal_o} !== 7'b0) begin nErr++; $display("FAIL reset_outputs got %b want 0000000", {fetch_req_o, mem_req_o, IRWrite_o, PCWrite_o, RegWrite_o, MemWrite_o, illegal_o}); end
        nVec++; if (instret_o !== 32'd0) begin nErr++; $display("FAIL reset_instret got %0d want 0", instret_o); end
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        nVec++; if (fetch_req_o !== 1'b1 || state_o !== 4'd0) begin nErr++; $display("FAIL reset_release got fetch=%b state=%0d want fetch=1 state=0", fetch_req_o, state_o); end
        nextCycle();
    endtask

    task automatic test_rtype;
        logic [31:0] tIns [8] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                  32'h0020C1B3, 32'h0020A1B3, 32'h002091B3, 32'h0020D1B3};
        logic [2:0]  tAlu [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 8; i++) begin
            instr_i = tIns[i]; instr_valid_i = 1'b1;
            @(negedge clk);
            nVec++; if (state_o !== 4'd0 || IRWrite_o !== 1'b1 || fetch_req_o !== 1'b1) begin nErr++; $display("FAIL r_fetch[%0d] got state=%0d ir=%b fetch=%b want 0/1/1", i, state_o, IRWrite_o, fetch_req_o); end
            nextCycle();
            instr_i = '0; instr_valid_i = 1'b0;
            @(negedge clk);
            nVec++; if (state_o !== 4'd1 || IRWrite_o !== 1'b0) begin nErr++; $display("FAIL r_decode[%0d] got state=%0d ir=%b want 1/0", i, state_o, IRWrite_o); end
            nextCycle();
            @(negedge clk);
            nVec++; if (state_o !== 4'd2 || ALUctrl_o !== tAlu[i] || ALUsrc_o !== 1'b0) begin nErr++; $display("FAIL r_exec[%0d] got state=%0d alu=%0d src=%b want 2/%0d/0", i, state_o, ALUctrl_o, ALUsrc_o, tAlu[i]); end
            nextCycle();
            @(negedge clk);
            nVec++; if (state_o !== 4'd7 || RegWrite_o !== 1'b1 || PCWrite_o !== 1'b1 || PCSrc_o !== 1'b0 || ResultSrc_o !== 2'b00) begin nErr++; $display("FAIL r_wb[%0d] got state=%0d rw=%b pcw=%b pcs=%b rs=%b want 7/1/1/0/00", i, state_o, RegWrite_o, PCWrite_o, PCSrc_o, ResultSrc_o); end
            nextCycle();
            expInstret++;
            nVec++; if (instret_o !== expInstret || state_o !== 4'd0) begin nErr++; $display("FAIL r_retire[%0d] got instret=%0d state=%0d want %0d/0", i, instret_o, state_o, expInstret); end
        end
    endtask

    task automatic test_itype;
        logic [31:0] tIns [6] = '{32'h00500093, 32'h40500093, 32'h00504093,
                                  32'h00505093, 32'h00502093, 32'h4050F093};
        logic [2:0]  tAlu [6] = '{3'd0, 3'd0, 3'd4, 3'd7, 3'd5, 3'd2};
        for (int i = 0; i < 6; i++) begin
            fetchDecode(tIns[i]);
            @(negedge clk);
            nVec++; if (state_o !== 4'd3 || ALUctrl_o !== tAlu[i] || ALUsrc_o !== 1'b1) begin nErr++; $display("FAIL i_exec[%0d] got state=%0d alu=%0d src=%b want 3/%0d/1", i, state_o, ALUctrl_o, ALUsrc_o, tAlu[i]); end
            nextCycle();
            @(negedge clk);
            nVec++; if (state_o !== 4'd7 || RegWrite_o !== 1'b1 || PCWrite_o !== 1'b1) begin nErr++; $display("FAIL i_wb[%0d] got state=%0d rw=%b pcw=%b want 7/1/1", i, state_o, RegWrite_o, PCWrite_o); end
            nextCycle();
            expInstret++;
        end
        nVec++; if (instret_o !== expInstret) begin nErr++; $display("FAIL i_instret got %0d want %0d", instret_o, expInstret); end
    endtask

    task automatic test_load;
        int cycles;
        fetchDecode(32'h0000A183);
        @(negedge clk);
        nVec++; if (state_o !== 4'd4 || ALUsrc_o !== 1'b1 || ALUctrl_o !== 3'd0) begin nErr++; $display("FAIL lw_addr got state=%0d src=%b alu=%0d want 4/1/0", state_o, ALUsrc_o, ALUctrl_o); end
        nextCycle();
        cycles = 3;
        for (int w = 0; w < 4; w++) begin
            mem_ready_i = (w == 3);
            @(negedge clk);
            nVec++; if (state_o !== 4'd5 || mem_req_o !== 1'b1 || MemWrite_o !== 1'b0 || PCWrite_o !== 1'b0) begin nErr++; $display("FAIL lw_rd[%0d] got state=%0d req=%b mw=%b pcw=%b want 5/1/0/0", w, state_o, mem_req_o, MemWrite_o, PCWrite_o); end
            nextCycle();
            cycles++;
        end
        mem_ready_i = 1'b0;
        @(negedge clk);
        cycles++;
        nVec++; if (state_o !== 4'd8 || ResultSrc_o !== 2'b01 || RegWrite_o !== 1'b1 || PCWrite_o !== 1'b1 || cycles !== 8) begin nErr++; $display("FAIL lw_wb got state=%0d rs=%b rw=%b pcw=%b cycle=%0d want 8/01/1/1/8", state_o, ResultSrc_o, RegWrite_o, PCWrite_o, cycles); end
        nextCycle();
        expInstret++;
        nVec++; if (instret_o !== expInstret || state_o !== 4'd0) begin nErr++; $display("FAIL lw_retire got instret=%0d state=%0d want %0d/0", instret_o, state_o, expInstret); end
    endtask

    task automatic test_store;
        fetchDecode(32'h0020A023);
        @(negedge clk);
        nVec++; if (state_o !== 4'd4 || ALUsrc_o !== 1'b1) begin nErr++; $display("FAIL sw_addr got state=%0d src=%b want 4/1", state_o, ALUsrc_o); end
        nextCycle();
        mem_ready_i = 1'b1;
        @(negedge clk);
        nVec++; if (state_o !== 4'd6 || mem_req_o !== 1'b1 || MemWrite_o !== 1'b1 || PCWrite_o !== 1'b1 || PCSrc_o !== 1'b0 || RegWrite_o !== 1'b0) begin nErr++; $display("FAIL sw_wr got state=%0d req=%b mw=%b pcw=%b pcs=%b rw=%b want 6/1/1/1/0/0", state_o, mem_req_o, MemWrite_o, PCWrite_o, PCSrc_o, RegWrite_o); end
        nextCycle();
        mem_ready_i = 1'b0;
        expInstret++;
        nVec++; if (instret_o !== expInstret || state_o !== 4'd0) begin nErr++; $display("FAIL sw_retire got instret=%0d state=%0d want %0d/0", instret_o, state_o, expInstret); end
    endtask

    task automatic test_branch;
        logic [31:0] tIns  [4] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
        logic        tZero [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        tSrc  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            fetchDecode(tIns[i]);
            zero_i = tZero[i];
            @(negedge clk);
            nVec++; if (state_o !== 4'd9 || PCWrite_o !== 1'b1 || PCSrc_o !== tSrc[i] || ALUctrl_o !== 3'd1 || ALUsrc_o !== 1'b0) begin nErr++; $display("FAIL br[%0d] got state=%0d pcw=%b pcs=%b alu=%0d src=%b want 9/1/%b/1/0", i, state_o, PCWrite_o, PCSrc_o, ALUctrl_o, ALUsrc_o, tSrc[i]); end
            nextCycle();
            zero_i = 1'b0;
            expInstret++;
            nVec++; if (state_o !== 4'd0 || instret_o !== expInstret) begin nErr++; $display("FAIL br_retire[%0d] got state=%0d instret=%0d want 0/%0d", i, state_o, instret_o, expInstret); end
        end
    endtask

    task automatic test_jal;
        fetchDecode(32'h000000EF);
        @(negedge clk);
        nVec++; if (state_o !== 4'd10 || RegWrite_o !== 1'b1 || ResultSrc_o !== 2'b10 || PCWrite_o !== 1'b1 || PCSrc_o !== 1'b1) begin nErr++; $display("FAIL jal got state=%0d rw=%b rs=%b pcw=%b pcs=%b want 10/1/10/1/1", state_o, RegWrite_o, ResultSrc_o, PCWrite_o, PCSrc_o); end
        nextCycle();
        expInstret++;
        nVec++; if (state_o !== 4'd0 || instret_o !== expInstret) begin nErr++; $display("FAIL jal_retire got state=%0d instret=%0d want 0/%0d", state_o, instret_o, expInstret); end
    endtask

    task automatic test_timeout_ok;
        fetchDecode(32'h0020A023);
        nextCycle();
        for (int w = 1; w <= 15; w++) begin
            mem_ready_i = (w == 15);
            @(negedge clk);
            nVec++; if (state_o !== 4'd6 || mem_req_o !== 1'b1 || PCWrite_o !== (w == 15)) begin nErr++; $display("FAIL sw_wait[%0d] got state=%0d req=%b pcw=%b want 6/1/%b", w, state_o, mem_req_o, PCWrite_o, (w == 15)); end
            nextCycle();
        end
        mem_ready_i = 1'b0;
        expInstret++;
        nVec++; if (state_o !== 4'd0 || illegal_o !== 1'b0 || instret_o !== expInstret) begin nErr++; $display("FAIL sw_late_ok got state=%0d ill=%b instret=%0d want 0/0/%0d", state_o, illegal_o, instret_o, expInstret); end
    endtask

    task automatic test_timeout_trap;
        fetchDecode(32'h0020A023);
        nextCycle();
        for (int w = 1; w <= 15; w++) begin
            @(negedge clk);
            nVec++; if (state_o !== 4'd6 || PCWrite_o !== 1'b0) begin nErr++; $display("FAIL sw_stall[%0d] got state=%0d pcw=%b want 6/0", w, state_o, PCWrite_o); end
            nextCycle();
        end
        instr_valid_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nVec++; if (state_o !== 4'd15 || illegal_o !== 1'b1 || {fetch_req_o, mem_req_o, IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, MemWrite_o} !== 7'b0) begin nErr++; $display("FAIL sw_trap[%0d] got state=%0d ill=%b en=%b want 15/1/0000000", c, state_o, illegal_o, {fetch_req_o, mem_req_o, IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, MemWrite_o}); end
            nextCycle();
        end
        nVec++; if (instret_o !== expInstret) begin nErr++; $display("FAIL trap_instret got %0d want %0d", instret_o, expInstret); end
        pulseReset();
        @(negedge clk);
        nVec++; if (state_o !== 4'd0 || illegal_o !== 1'b0 || instret_o !== 32'd0) begin nErr++; $display("FAIL trap_cleared got state=%0d ill=%b instret=%0d want 0/0/0", state_o, illegal_o, instret_o); end
        nextCycle();
    endtask

    task automatic test_illegal;
        fetchDecode(32'h0000007F);
        instr_valid_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nVec++; if (state_o !== 4'd15 || illegal_o !== 1'b1 || {fetch_req_o, mem_req_o, IRWrite_o, PCWrite_o, PCSrc_o, ALUsrc_o, RegWrite_o, MemWrite_o} !== 8'b0) begin nErr++; $display("FAIL op7f_trap[%0d] got state=%0d ill=%b en=%b want 15/1/00000000", c, state_o, illegal_o, {fetch_req_o, mem_req_o, IRWrite_o, PCWrite_o, PCSrc_o, ALUsrc_o, RegWrite_o, MemWrite_o}); end
            nextCycle();
        end
        pulseReset();
        fetchDecode(32'h4020D1B3);
        @(negedge clk);
        nVec++; if (state_o !== 4'd2 || RegWrite_o !== 1'b0) begin nErr++; $display("FAIL sra_exec got state=%0d rw=%b want 2/0", state_o, RegWrite_o); end
        nextCycle();
        @(negedge clk);
        nVec++; if (state_o !== 4'd15 || illegal_o !== 1'b1 || PCWrite_o !== 1'b0) begin nErr++; $display("FAIL sra_trap got state=%0d ill=%b pcw=%b want 15/1/0", state_o, illegal_o, PCWrite_o); end
        pulseReset();
        fetchDecode(32'h0020B463);
        @(negedge clk);
        nVec++; if (state_o !== 4'd9 || PCWrite_o !== 1'b0) begin nErr++; $display("FAIL br_bad_f3 got state=%0d pcw=%b want 9/0", state_o, PCWrite_o); end
        nextCycle();
        @(negedge clk);
        nVec++; if (state_o !== 4'd15) begin nErr++; $display("FAIL br_bad_trap got state=%0d want 15", state_o); end
        pulseReset();
    endtask

    task automatic test_reset_mid;
        fetchDecode(32'h000000EF);
        nextCycle();
        expInstret++;
        fetchDecode(32'h0020A023);
        nextCycle();
        @(negedge clk);
        nVec++; if (state_o !== 4'd6 || MemWrite_o !== 1'b1 || instret_o !== expInstret) begin nErr++; $display("FAIL mid_pre got state=%0d mw=%b instret=%0d want 6/1/%0d", state_o, MemWrite_o, instret_o, expInstret); end
        #1 rst_n = 1'b0;
        #1;
        nVec++; if (state_o !== 4'd0 || MemWrite_o !== 1'b0 || mem_req_o !== 1'b0 || PCWrite_o !== 1'b0 || instret_o !== 32'd0) begin nErr++; $display("FAIL mid_reset got state=%0d mw=%b req=%b pcw=%b instret=%0d want 0/0/0/0/0", state_o, MemWrite_o, mem_req_o, PCWrite_o, instret_o); end
        nextCycle();
        rst_n = 1'b1;
        expInstret = '0;
        @(negedge clk);
        nVec++; if (state_o !== 4'd0 || fetch_req_o !== 1'b1 || MemWrite_o !== 1'b0) begin nErr++; $display("FAIL mid_release got state=%0d fetch=%b mw=%b want 0/1/0", state_o, fetch_req_o, MemWrite_o); end
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_load();
        test_store();
        test_branch();
        test_jal();
        test_timeout_ok();
        test_timeout_trap();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
